// File: rtl/gauss_seq_ctrl.sv
// Sequencer for the 11x11 blur datapath: column/row counting, line-buffer
// priming, frame-stable kernel select and a delayed filtered-output valid.
module gauss_seq_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned KERNEL   = 11,
    parameter int unsigned PIPE_LAT = 1,
    parameter int unsigned COL_W    = 13,
    parameter int unsigned ROW_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [1:0]       filt_sel_in,
    output logic [COL_W-1:0] col,
    output logic             buff_en,
    output logic             shift_en,
    output logic [1:0]       filt_sel,
    output logic [ROW_W-1:0] row,
    output logic             out_valid,
    output logic [COL_W-1:0] out_col,
    output logic             primed,
    output logic             sync_err,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int unsigned LC_W = $clog2(KERNEL + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
    localparam logic [LC_W-1:0]  LC_FULL  = LC_W'(KERNEL);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [LC_W-1:0]   lcnt_q, lcnt_d;
    logic              shift_q, shift_d;
    logic [1:0]        fsel_q, fsel_d;
    logic              primed_q, primed_d;
    logic              sync_q, sync_d;
    logic [PIPE_LAT-1:0] pv_q, pv_d;
    logic [COL_W-1:0]  pc_q [PIPE_LAT];
    logic [COL_W-1:0]  pc_d [PIPE_LAT];
    logic              accept;
    logic              in_v;
    logic              flush;

    assign accept = pix_valid & ((state_q == PRIME) | (state_q == RUN));

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        lcnt_d   = lcnt_q;
        shift_d  = 1'b0;
        fsel_d   = fsel_q;
        primed_d = primed_q;
        sync_d   = 1'b0;
        in_v     = 1'b0;
        flush    = 1'b0;

        // priority: disable, then frame_start, then normal pixel acceptance
        if (!enable) begin
            state_d = IDLE;
            flush   = 1'b1;
        end else if (frame_start) begin
            sync_d   = (state_q != IDLE);
            flush    = (state_q != IDLE);
            col_d    = '0;
            row_d    = '0;
            lcnt_d   = '0;
            primed_d = 1'b0;
            fsel_d   = filt_sel_in;
            state_d  = PRIME;
        end else if (accept) begin
            in_v = (state_q == RUN);
            if (col_q == COL_LAST) begin
                col_d   = '0;
                shift_d = 1'b1;
                if (lcnt_q != LC_FULL) begin
                    lcnt_d = lcnt_q + 1'b1;
                end
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                if ((state_q == PRIME) && (lcnt_d == LC_FULL)) begin
                    primed_d = 1'b1;
                    state_d  = RUN;
                end else if (row_q == ROW_LAST) begin
                    state_d = IDLE;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        pv_d[0] = in_v;
        pc_d[0] = col_q;
        for (int unsigned i = 1; i < PIPE_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pc_d[i] = pc_q[i-1];
        end
        if (flush) begin
            pv_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            lcnt_q   <= '0;
            shift_q  <= 1'b0;
            fsel_q   <= '0;
            primed_q <= 1'b0;
            sync_q   <= 1'b0;
            pv_q     <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            lcnt_q   <= lcnt_d;
            shift_q  <= shift_d;
            fsel_q   <= fsel_d;
            primed_q <= primed_d;
            sync_q   <= sync_d;
            pv_q     <= pv_d;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                pc_q[i] <= pc_d[i];
            end
        end
    end

    assign buff_en   = accept;
    assign col       = col_q;
    assign row       = row_q;
    assign shift_en  = shift_q;
    assign filt_sel  = fsel_q;
    assign primed    = primed_q;
    assign sync_err  = sync_q;
    assign state     = state_q;
    assign out_valid = pv_q[PIPE_LAT-1];
    assign out_col   = pc_q[PIPE_LAT-1];

endmodule

// File: tb/tb_gauss_seq_ctrl.sv
// Self-checking bench for gauss_seq_ctrl: behavioural frame model compared
// every cycle, plus directed literal checks and a randomized phase.
module tb_gauss_seq_ctrl;

    localparam int H  = 8;
    localparam int V  = 16;
    localparam int K  = 3;
    localparam int PL = 1;

    logic        clk, rst_n, enable, frame_start, pix_valid;
    logic [1:0]  filt_sel_in;
    logic [12:0] col, out_col;
    logic [9:0]  row;
    logic        buff_en, shift_en, out_valid, primed, sync_err;
    logic [1:0]  filt_sel, state;

    gauss_seq_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .KERNEL(K), .PIPE_LAT(PL),
                     .COL_W(13), .ROW_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
        .pix_valid(pix_valid), .filt_sel_in(filt_sel_in), .col(col),
        .buff_en(buff_en), .shift_en(shift_en), .filt_sel(filt_sel), .row(row),
        .out_valid(out_valid), .out_col(out_col), .primed(primed),
        .sync_err(sync_err), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a frame is V lines of H accepted pixels; output
    // valid only for pixels taken after K lines have been shifted in.
    typedef struct { bit v; int c; } pent_t;
    int    m_state, m_col, m_row, m_lines, m_fsel;
    bit    m_shift, m_sync, m_primed;
    pent_t m_pipe[$];
    pent_t m_out;

    task automatic m_flush();
        m_pipe.delete();
        for (int i = 0; i < PL - 1; i++) m_pipe.push_back('{v: 0, c: 0});
        m_out = '{v: 0, c: 0};
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_col = 0; m_row = 0; m_lines = 0; m_fsel = 0;
            m_shift = 0; m_sync = 0; m_primed = 0;
            m_flush();
        end else begin
            pent_t e;
            bit last_row;
            e = '{v: 0, c: m_col};
            m_shift = 0;
            m_sync = 0;
            if (!enable) begin
                m_state = 0;
                m_flush();
            end else if (frame_start) begin
                if (m_state != 0) begin
                    m_sync = 1;
                    m_flush();
                end else begin
                    m_pipe.push_back(e);
                    m_out = m_pipe.pop_front();
                end
                m_col = 0; m_row = 0; m_lines = 0; m_primed = 0;
                m_fsel = int'(filt_sel_in);
                m_state = 1;
            end else begin
                if (pix_valid && m_state != 0) begin
                    e.v = (m_state == 2);
                    if (m_col == H - 1) begin
                        m_col = 0;
                        m_shift = 1;
                        if (m_lines < K) m_lines++;
                        last_row = (m_row == V - 1);
                        m_row = last_row ? 0 : m_row + 1;
                        if (m_state == 1 && m_lines == K) begin
                            m_primed = 1;
                            m_state = 2;
                        end else if (last_row) begin
                            m_state = 0;
                        end
                    end else begin
                        m_col++;
                    end
                end
                m_pipe.push_back(e);
                m_out = m_pipe.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        chk("col", int'(col), m_col);
        chk("row", int'(row), m_row);
        chk("state", int'(state), m_state);
        chk("shift_en", int'(shift_en), int'(m_shift));
        chk("sync_err", int'(sync_err), int'(m_sync));
        chk("primed", int'(primed), int'(m_primed));
        chk("filt_sel", int'(filt_sel), m_fsel);
        chk("buff_en", int'(buff_en), int'(pix_valid && m_state != 0));
        chk("out_valid", int'(out_valid), int'(m_out.v));
        if (m_out.v) chk("out_col", int'(out_col), m_out.c);
    end

    int sh_cnt = 0;
    always @(negedge clk) if (shift_en) sh_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic line(input int gap);
        for (int p = 0; p < H; p++) begin
            pix_valid = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
    endtask

    task automatic start_frame(input logic [1:0] fs);
        filt_sel_in = fs;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0;
        pix_valid = 1'b1; filt_sel_in = 2'd3;
        #3;
        chk("rst_state", int'(state), 0);
        chk("rst_buff_en", int'(buff_en), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        tick(); tick();
        rst_n = 1'b1;
        pix_valid = 1'b0;
        tick();

        // frame 1: priming then full run
        sh_cnt = 0;
        start_frame(2'd1);
        chk("fs_state", int'(state), 1);
        for (int ln = 0; ln < 3; ln++) line(2);
        chk("prime_state", int'(state), 2);
        chk("prime_primed", int'(primed), 1);
        chk("prime_shifts", sh_cnt, 3);
        line(0);
        pix_valid = 1'b1;
        #1;
        chk("b2b_shift_en", int'(shift_en), 1);
        chk("b2b_col", int'(col), 0);
        chk("b2b_buff_en", int'(buff_en), 1);
        for (int ln = 4; ln < V; ln++) line((ln == V - 1) ? 0 : 1);
        chk("end_state", int'(state), 0);
        chk("end_out_valid", int'(out_valid), 1);
        chk("end_out_col", int'(out_col), 7);
        tick();
        chk("end_shifts", sh_cnt, 16);

        // frame 2: filt_sel stability and mid-frame resync
        start_frame(2'd1);
        filt_sel_in = 2'd2;
        for (int ln = 0; ln < 5; ln++) line(1);
        for (int p = 0; p < 3; p++) begin
            pix_valid = 1'b1;
            tick();
        end
        chk("fsel_hold", int'(filt_sel), 1);
        chk("pre_sync_col", int'(col), 3);
        chk("pre_sync_row", int'(row), 5);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pix_valid = 1'b0;
        chk("sync_err", int'(sync_err), 1);
        chk("sync_row", int'(row), 0);
        chk("sync_col", int'(col), 0);
        chk("sync_primed", int'(primed), 0);
        chk("sync_state", int'(state), 1);
        chk("sync_fsel", int'(filt_sel), 2);
        chk("sync_shift", int'(shift_en), 0);
        chk("sync_out_valid", int'(out_valid), 0);
        tick();
        chk("sync_err_drop", int'(sync_err), 0);

        // disable in RUN
        for (int ln = 0; ln < 3; ln++) line(1);
        pix_valid = 1'b1;
        tick(); tick();
        sh_cnt = 0;
        for (int p = 0; p < H; p++) begin
            enable = (p == 0) ? 1'b0 : enable;
            tick();
            if (p == 0) begin
                chk("dis_state", int'(state), 0);
                chk("dis_out_valid", int'(out_valid), 0);
            end
        end
        chk("dis_shifts", sh_cnt, 0);
        pix_valid = 1'b0;
        enable = 1'b1;
        tick();

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            enable      = ($urandom_range(0, 199) != 0);
            frame_start = ($urandom_range(0, 159) == 0);
            pix_valid   = ($urandom_range(0, 9) < 8);
            filt_sel_in = 2'($urandom_range(0, 3));
            tick();
        end
        frame_start = 1'b0;
        pix_valid = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gauss_seq_ctrl.md
Name: gauss_seq_ctrl

Overview:
- Sequencer for the 11x11 Gaussian/box blur datapath on the D8M camera path.
- Turns the camera pixel stream into the datapath's column index, line-buffer write enable and line-shift pulse.
- Counts rows, tracks line-buffer priming, latches the kernel select at frame boundaries, and flags when the filtered output is valid.
- Sits between the camera/VGA timing logic and the blur datapath.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
KERNEL, 11, lines that must be shifted in before output is valid
PIPE_LAT, 1, datapath latency in clocks from pixel accept to filtered pixel
COL_W, 13, width of column index
ROW_W, 10, width of row counter

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  block enable; low forces IDLE
frame_start  in  1  one-cycle pulse at the start of a frame
pix_valid  in  1  current input pixel is active
filt_sel_in  in  2  requested kernel select
col  out  COL_W  index of the pixel accepted this cycle
buff_en  out  1  line-buffer write strobe
shift_en  out  1  one-cycle line-shift pulse
filt_sel  out  2  kernel select, frame-stable
row  out  ROW_W  current input line
out_valid  out  1  filtered pixel valid
out_col  out  COL_W  column of the filtered pixel
primed  out  1  KERNEL lines shifted into this frame
sync_err  out  1  one-cycle pulse on a mid-frame frame_start
state  out  2  IDLE=0, PRIME=1, RUN=2

Behaviour:
- Reset (async, rst_n=0) clears every register: col=0, row=0, shift_en=0, filt_sel=0, out_valid=0, out_col=0, primed=0, sync_err=0, state=IDLE, internal line count lcnt=0, latency pipe cleared.
- buff_en = pix_valid & (state==PRIME | state==RUN). It is combinational, so it is 0 during reset and in IDLE.
- col: registered. Increments on each accepted pixel. On an accepted pixel with col==H_ACTIVE-1 it wraps to 0, row increments and lcnt increments (lcnt saturates at KERNEL).
- shift_en: registered. High for exactly one clock, the clock after the last pixel of a line is accepted.
- A pixel accepted in the same clock as shift_en is written normally at col 0. The datapath's nonblocking shift reads the old buff contents, so no hazard exists.
- IDLE:
  - enable & frame_start -> PRIME. In that clock: col=0, row=0, lcnt=0, primed=0, filt_sel<=filt_sel_in.
  - pix_valid is ignored.
- PRIME:
  - On the wrap that takes lcnt to KERNEL: primed=1 -> RUN (next clock).
  - If V_ACTIVE is reached first: -> IDLE.
- RUN:
  - out_valid/out_col = pix_valid/col delayed by PIPE_LAT clocks, gated by state==RUN at accept time.
  - Wrap with row==V_ACTIVE-1 -> IDLE; row cleared to 0. The final shift_en still fires.
  - The pipe drains: the last PIPE_LAT outputs still emit in IDLE.
- frame_start while in PRIME or RUN:
  - sync_err pulses for one clock.
  - Counters clear, filt_sel is relatched, state -> PRIME.
  - Any pending shift_en is suppressed.
  - Pixels in the latency pipe are discarded (out_valid=0 from the next clock).
- enable=0 in any state: -> IDLE next clock. Counters hold, shift_en and out_valid are forced 0, and the pipe is flushed.
- filt_sel changes only on an accepted frame_start. filt_sel_in changes mid-frame have no effect.
- frame_start and a line wrap in the same clock: frame_start wins, and no shift_en is issued.
- row and col never exceed V_ACTIVE-1 and H_ACTIVE-1.

Test Plan:
- Reset check: hold rst_n=0 with pix_valid=1, then release -> all outputs 0, state=0, buff_en=0, with no clock edge needed to clear.
- Priming (H_ACTIVE=8, V_ACTIVE=16, KERNEL=3): frame_start, then 3 lines of 8 pixels with 2-clock gaps ->
  - col counts 0..7 on each line;
  - shift_en pulses 3 times, one clock after each col=7 accept;
  - primed=1 and state=2 after the third wrap;
  - out_valid=0 throughout.
- RUN latency (PIPE_LAT=1): line 4 -> out_valid high one clock after each accept, with out_col 0..7 matching. Back-to-back pixel at col 0 in the shift_en clock -> buff_en=1 and col=0 in that clock.
- Frame end: 16 full lines -> 16 shift_en pulses, state returns to 0 after the row=15 wrap, and the last out_valid (col 7) still appears.
- Mid-frame resync: frame_start at row 5, col 3 with filt_sel_in=2 ->
  - sync_err one clock;
  - row=0, col=0, primed=0, state=1, filt_sel=2;
  - no shift_en; out_valid drops next clock.
- filt_sel stability and disable:
  - filt_sel_in 1->2 mid-frame -> filt_sel stays 1 until the next frame_start.
  - enable=0 in RUN -> state=0 next clock, out_valid=0, shift_en never pulses.
